c7bbiu_ird: RTL and testbench
=============================

# c7bbiu_ird

Instruction read port of the bus interface unit, directly downstream of the instruction cache unit. Accepts one linefill or single-beat read request at a time from the cache's miss path and turns it into an AXI4 read burst. Returns the 64-bit beats to the cache with valid, last and fault qualifiers. Only one transaction is outstanding at any time, and the cache side applies no backpressure.

## Interface
Parameters:
- AXI_ID, default 4'h0: constant driven on arid.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous and active-low.
- icu_biu_req  in  1  read request; held high by the cache until acked.
- icu_biu_addr  in  29  [31:3] doubleword address; 32-byte aligned for linefills.
- icu_biu_single  in  1  1 = single 64-bit beat, 0 = 4-beat linefill.
- biu_icu_ack  out  1  one-cycle pulse; request accepted.
- biu_icu_data_valid  out  1  beat valid.
- biu_icu_data_last  out  1  final beat; only asserted with data_valid.
- biu_icu_data  out  64  beat data.
- biu_icu_fault  out  1  beat error; only asserted with data_valid.
- arid  out  4  fixed AXI_ID.
- araddr  out  32  {addr[31:3], 3'b000}.
- arlen  out  8  0 when single, 3 when linefill.
- arsize  out  3  fixed 3'b011.
- arburst  out  2  fixed 2'b01 (INCR).
- arvalid  out  1  address valid.
- arready  in  1  address accepted.
- rdata  in  64  read data.
- rresp  in  2  read response.
- rlast  in  1  last beat.
- rvalid  in  1  beat valid.
- rready  out  1  beat accepted.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - biu_icu_ack = icu_biu_req (combinational).
  - On ack: capture addr and single into registers, clear beat counter, go to ADDR.
- ADDR:
  - arvalid=1; araddr, arlen and arid come from registers and stay stable until the handshake.
  - On arvalid & arready: go to DATA.
- DATA:
  - rready=1.
  - Each rvalid beat increments the 2-bit beat counter.
  - On rvalid & rlast: go to IDLE.
- A beat is faulted when either condition holds:
  - rresp[1]=1 (SLVERR or DECERR);
  - rlast arrives with beat counter != arlen[1:0], which is a protocol mismatch.
- When a fault occurs, the remaining beats are still consumed and delivered to the cache.
- biu_icu_data_last = delivered beat & rlast. The rlast value is forwarded as received, so a short burst is not padded with extra beats.
- A request arriving while the FSM is not in IDLE is not acked. The cache holds the request, and it is acked in the first IDLE cycle.
- icu_biu_single and addr are sampled only at ack.

## Timing
- Reset values: all outputs 0, except arid=AXI_ID, arsize=3'b011 and arburst=2'b01. FSM state is IDLE.
- Reset during ADDR or DATA:
  - immediate return to IDLE; arvalid and rready drop asynchronously;
  - the partial burst is abandoned, because the interconnect is reset on the same resetn.
- Ack occurs in cycle t. arvalid is first high in cycle t+1.
- Beat delivery (without macro): beat outputs are a combinational pass-through of the R channel in the same cycle as rvalid & rready.
- Earliest new ack: the cycle after the beat carrying rlast.
- Minimum linefill: ack at t; address handshake at t+1; beats at t+2 to t+5; next ack at t+6.
- rvalid outside DATA is ignored, because rready=0 there.

## Configuration
- C7B_BIU_RDATA_REG_EN defined:
  - rdata, rlast and fault status are registered before output;
  - biu_icu_data_valid, data_last and fault appear one cycle after the R handshake, with reset value 0;
  - the next ack is delayed until the registered last beat has been output, one extra cycle.
- C7B_BIU_RDATA_REG_EN undefined:
  - combinational pass-through as described above, with no added latency.

## Test plan
- Linefill, no stalls:
  - Stimulus: req with addr=0x1000_0020>>3, single=0, arready=1, beats D0..D3 back-to-back.
  - Expected: ack one cycle; araddr=0x10000020, arlen=3; four data_valid pulses, last only on D3; fault=0.
- Single beat:
  - Stimulus: single=1, addr=0x0000_0108>>3.
  - Expected: araddr=0x108, arlen=0; one valid beat with last=1.
- arready stall and gapped rvalid:
  - Stimulus: arready low 3 cycles, then beats with 2-cycle gaps.
  - Expected: arvalid and araddr are stable throughout the stall; data_valid follows rvalid exactly; no ack while busy even with req held high.
- Error response:
  - Stimulus: beat 2 returns rresp=2'b10.
  - Expected: fault=1 on beat 2 only; beat 3 is still delivered with last=1.
- rlast early:
  - Stimulus: linefill whose rlast arrives on beat 1.
  - Expected: beat 1 has last=1 and fault=1; the FSM returns to IDLE and the next req is acked the following cycle.
- Reset mid-burst:
  - Stimulus: resetn low after beat 1.
  - Expected: all outputs return to their reset values asynchronously; after release, a fresh req is acked normally.

Source files
------------

// File: rtl/c7bbiu_ird.sv
// ---------------------------------------------------------------------------
// c7bbiu_ird -- instruction read port of the bus interface unit.
//
// Sits below the instruction cache miss path. It takes one linefill (4 x 64b)
// or single-beat read request at a time and issues it as an AXI4 INCR read
// burst. The returned beats go back to the cache with valid/last/fault
// qualifiers. Only one transaction is in flight, and the cache never
// backpressures the beat return.
//
// Optional feature (compile-time macro):
//   C7B_BIU_RDATA_REG_EN  register the R-channel beat (data, last, fault)
//                         before it is presented to the cache. This adds one
//                         cycle of beat latency and holds off the next ack
//                         until the registered last beat has been output.
//                         When undefined, beats pass straight through.
//
// Parameters:
//   AXI_ID              constant driven on arid
//
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   icu_biu_req         cache read request (held until acked)
//   icu_biu_addr        doubleword address [31:3]
//   icu_biu_single      1 = single beat, 0 = 4-beat linefill
//   biu_icu_ack         request accepted (combinational while idle)
//   biu_icu_data_valid  beat valid
//   biu_icu_data_last   final beat (qualified by valid)
//   biu_icu_data        beat data
//   biu_icu_fault       beat error (qualified by valid)
//   ar*                 AXI4 read address channel (master side)
//   r*                  AXI4 read data channel (master side)
// ---------------------------------------------------------------------------
module c7bbiu_ird #(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        clk,
  input  logic        resetn,
  // cache side
  input  logic        icu_biu_req,
  input  logic [28:0] icu_biu_addr,
  input  logic        icu_biu_single,
  output logic        biu_icu_ack,
  output logic        biu_icu_data_valid,
  output logic        biu_icu_data_last,
  output logic [63:0] biu_icu_data,
  output logic        biu_icu_fault,
  // AXI4 read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI4 read data channel
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e      state_q;
  logic [28:0] addr_q;
  logic [7:0]  arlen_q;
  logic [1:0]  beat_cnt_q;
  logic        arvalid_q;
  logic        rready_q;

  logic        beat_hs;
  logic        beat_fault;
  logic        ack_blk;
  // Only rresp[1] distinguishes an error response; OKAY/EXOKAY are both fine.
  logic        rresp_lo_unused;

  assign rresp_lo_unused = rresp[0];

  // ---------------------------------------------------------------------
  // Fixed and registered AR channel fields
  // ---------------------------------------------------------------------
  assign arid    = AXI_ID;
  assign arsize  = 3'b011;
  assign arburst = 2'b01;
  assign araddr  = {addr_q, 3'b000};
  assign arlen   = arlen_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  // ---------------------------------------------------------------------
  // Beat qualification
  // ---------------------------------------------------------------------
  // rready is only high in DATA, so any rvalid outside DATA is ignored.
  assign beat_hs = rvalid & rready_q;

  // A beat is faulted on an error response, or when rlast shows up on a
  // beat other than the one the burst length predicts (short or long burst).
  assign beat_fault = rresp[1] | (rlast & (beat_cnt_q != arlen_q[1:0]));

  // Ack is combinational in IDLE; the cache holds req until it sees it.
  assign biu_icu_ack = icu_biu_req & (state_q == IDLE) & ~ack_blk;

  // ---------------------------------------------------------------------
  // Control FSM with registered AR/R handshake outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      arlen_q    <= '0;
      beat_cnt_q <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (biu_icu_ack) begin
            // Address and size are sampled only here.
            addr_q     <= icu_biu_addr;
            arlen_q    <= icu_biu_single ? 8'd0 : 8'd3;
            beat_cnt_q <= '0;
            arvalid_q  <= 1'b1;
            state_q    <= ADDR;
          end
        end
        ADDR: begin
          // AR fields come from registers and hold until the handshake.
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          // Faulted bursts are still drained to rlast; the beat counter
          // simply wraps if the slave overruns a linefill.
          if (beat_hs) begin
            beat_cnt_q <= beat_cnt_q + 2'd1;
            if (rlast) begin
              rready_q <= 1'b0;
              state_q  <= IDLE;
            end
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Beat return path
  // ---------------------------------------------------------------------
`ifdef C7B_BIU_RDATA_REG_EN
  logic        vld_q;
  logic        last_q;
  logic        fault_q;
  logic [63:0] data_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      fault_q <= 1'b0;
      data_q  <= '0;
    end else begin
      vld_q   <= beat_hs;
      last_q  <= beat_hs & rlast;
      fault_q <= beat_hs & beat_fault;
      if (beat_hs) data_q <= rdata;
    end
  end

  assign biu_icu_data_valid = vld_q;
  assign biu_icu_data_last  = last_q;
  assign biu_icu_fault      = fault_q;
  assign biu_icu_data       = data_q;

  // The FSM is already back in IDLE while the registered last beat is still
  // on its way out; hold the next ack until that beat has been presented.
  assign ack_blk = last_q;
`else
  // Straight pass-through in the handshake cycle. Data is zeroed when no
  // beat is delivered so the cache never sees stale bus data.
  assign biu_icu_data_valid = beat_hs;
  assign biu_icu_data_last  = beat_hs & rlast;
  assign biu_icu_fault      = beat_hs & beat_fault;
  assign biu_icu_data       = beat_hs ? rdata : 64'd0;

  assign ack_blk = 1'b0;
`endif

endmodule

// File: tb/tb_c7bbiu_ird.sv
module tb_c7bbiu_ird;

`ifdef C7B_BIU_RDATA_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  localparam logic [3:0] ID = 4'hA;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        icu_biu_req = 1'b0;
  logic [28:0] icu_biu_addr = '0;
  logic        icu_biu_single = 1'b0;
  logic        biu_icu_ack, biu_icu_data_valid, biu_icu_data_last, biu_icu_fault;
  logic [63:0] biu_icu_data;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, rready;
  logic        arready = 1'b0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;

  c7bbiu_ird #(.AXI_ID(ID)) dut (
    .clk(clk), .resetn(resetn),
    .icu_biu_req(icu_biu_req), .icu_biu_addr(icu_biu_addr), .icu_biu_single(icu_biu_single),
    .biu_icu_ack(biu_icu_ack), .biu_icu_data_valid(biu_icu_data_valid),
    .biu_icu_data_last(biu_icu_data_last), .biu_icu_data(biu_icu_data),
    .biu_icu_fault(biu_icu_fault),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int next_ack_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected beat as the cache should see it, with the cycle it must appear in.
  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        fault;
    int          at;
  } beat_t;
  beat_t exp_q[$];

  // Beat monitor: every delivered beat must match the next expected one.
  always @(negedge clk) begin : mon
    beat_t e;
    if (resetn) begin
      if (biu_icu_data_valid) begin
        if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat_data",  biu_icu_data,      e.data);
          chk("beat_last",  biu_icu_data_last, e.last);
          chk("beat_fault", biu_icu_fault,     e.fault);
          chk("beat_cycle", cyc,               e.at);
        end
      end else begin
        chk("qual_without_valid", {biu_icu_data_last, biu_icu_fault}, 2'b00);
      end
    end
  end

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_ack"},     biu_icu_ack,        0);
    chk({pfx, "_valid"},   biu_icu_data_valid, 0);
    chk({pfx, "_last"},    biu_icu_data_last,  0);
    chk({pfx, "_fault"},   biu_icu_fault,      0);
    chk({pfx, "_data"},    biu_icu_data,       0);
    chk({pfx, "_arvalid"}, arvalid,            0);
    chk({pfx, "_rready"},  rready,             0);
    chk({pfx, "_araddr"},  araddr,             0);
    chk({pfx, "_arlen"},   arlen,              0);
    chk({pfx, "_arid"},    arid,               ID);
    chk({pfx, "_arsize"},  arsize,             3'b011);
    chk({pfx, "_arburst"}, arburst,            2'b01);
  endtask

  // Reset asserted mid-burst, between clock edges.
  task automatic do_reset();
    @(negedge clk);
    chk("rready_before_reset", rready, 1);
    #2;
    resetn      = 1'b0;
    icu_biu_req = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    chk("sb_empty_at_reset", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
    next_ack_cyc = 0;
  endtask

  // One request/burst. gap<0 = random 0..2 idle cycles before each beat;
  // err_beat = beat with an error response (-1 none); early = beat index that
  // carries rlast (-1 = natural length); rst_after = reset after that beat.
  task automatic run_txn(input logic [28:0] a, input bit sgl, input int stall, input int gap,
                         input int err_beat, input int early, input int rst_after);
    int    n, nb, g, exp_ack;
    bit    got;
    logic [7:0] len;
    beat_t e;
    len     = sgl ? 8'd0 : 8'd3;
    exp_ack = (next_ack_cyc > cyc) ? next_ack_cyc : cyc;
    icu_biu_req    = 1'b1;
    icu_biu_addr   = a;
    icu_biu_single = sgl;
    got = 0;
    n   = 0;
    while (!got && n < 16) begin
      @(negedge clk);
      if (biu_icu_ack) got = 1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk("ack_seen", got, 1);
    if (!got) return;
    chk("ack_cycle", cyc, exp_ack);
    chk("arvalid_at_ack", arvalid, 0);
    @(posedge clk);
    #1;
    // Keep req up with a different payload: must be neither acked nor sampled.
    icu_biu_addr   = 29'($urandom);
    icu_biu_single = 1'($urandom);
    for (int i = 0; i <= stall; i++) begin
      arready = (i == stall);
      @(negedge clk);
      chk("arvalid",     arvalid, 1);
      chk("araddr",      araddr,  {a, 3'b000});
      chk("arlen",       arlen,   len);
      chk("arid",        arid,    ID);
      chk("ack_in_addr", biu_icu_ack, 0);
      chk("rready_addr", rready,  0);
      @(posedge clk);
      #1;
    end
    arready = 1'b0;
    nb = (early >= 0) ? early + 1 : int'(len) + 1;
    for (int b = 0; b < nb; b++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        @(negedge clk);
        chk("rready_gap",   rready,      1);
        chk("ack_in_data",  biu_icu_ack, 0);
        chk("arvalid_data", arvalid,     0);
        @(posedge clk);
        #1;
      end
      rvalid = 1'b1;
      rdata  = {$urandom, $urandom};
      rlast  = (b == nb - 1);
      rresp  = (b == err_beat) ? {1'b1, 1'($urandom)} : {1'b0, 1'($urandom)};
      e.data  = rdata;
      e.last  = rlast;
      e.fault = rresp[1] || (rlast && b != int'(len));
      e.at    = cyc + LAT;
      exp_q.push_back(e);
      @(negedge clk);
      chk("rready_beat", rready,      1);
      chk("ack_in_data", biu_icu_ack, 0);
      @(posedge clk);
      #1;
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      if (b == rst_after) begin
        do_reset();
        return;
      end
    end
    next_ack_cyc = cyc + LAT;
  endtask

  task automatic idle(input int n);
    icu_biu_req = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [28:0] a;
    bit          sgl;
    int          err, early;
    #3;
    chk_reset_outputs("reset");
    @(negedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;

    // linefill, no stalls
    run_txn(29'h200_0004, 1'b0, 0, 0, -1, -1, -1);
    // single beat
    run_txn(29'h21, 1'b1, 0, 0, -1, -1, -1);
    // arready stall, 2-cycle beat gaps, req held throughout
    run_txn(29'h0ab_cd04, 1'b0, 3, 2, -1, -1, -1);
    // error response on beat 2
    run_txn(29'h000_1000, 1'b0, 0, 0, 2, -1, -1);
    // rlast early on beat 1, then back-to-back request
    run_txn(29'h000_2008, 1'b0, 1, 0, -1, 1, -1);
    run_txn(29'h000_3000, 1'b1, 0, 1, -1, -1, -1);
    // reset after beat 1, then a fresh request
    run_txn(29'h000_4000, 1'b0, 0, 0, -1, -1, 1);
    run_txn(29'h000_5000, 1'b0, 0, 0, -1, -1, -1);
    idle(3);

    for (int t = 0; t < 40; t++) begin
      a   = 29'($urandom);
      sgl = 1'($urandom);
      if (!sgl) a[1:0] = 2'b00;
      err   = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, 3)) : -1;
      early = (!sgl && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_txn(a, sgl, int'($urandom_range(0, 3)), -1, err, early, -1);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(4);
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
